// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe controller: state encoding,
// grid width and the eight winning line masks.
package tictactoe_pkg;

  localparam int GRID_W = 9;

  // Encoding is visible on gameState_tc, so values are fixed.
  typedef enum logic [2:0] {
    ST_P1_TURN = 3'd0,
    ST_P2_TURN = 3'd1,
    ST_P1_WIN  = 3'd2,
    ST_P2_WIN  = 3'd3,
    ST_DRAW    = 3'd4,
    ST_CHECK   = 3'd5
  } state_t;

  // Bit index = 3*row+col: three rows, three columns, two diagonals.
  localparam logic [GRID_W-1:0] WIN_LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

endpackage

// File: rtl/line_checker.sv
// Combinational win detector: flags any complete line in one grid.
module line_checker
  import tictactoe_pkg::*;
(
  input  logic [GRID_W-1:0] grid,
  output logic              win
);

  // OR over all lines of "every cell of the line is occupied".
  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((grid & WIN_LINES[i]) == WIN_LINES[i]) win = 1'b1;
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn sequencer: owns both grids, arbitrates placements,
// runs the per-turn timeout and resolves win/draw one cycle after a move.
//
// Request interface: place_req_tc and restart_tc are single-cycle pulses
// sampled on the clock edge; there is no back-pressure. Every sampled
// placement in a turn state is answered on the following cycle by exactly
// one of place_ack_tc / place_nack_tc, or superseded by timeout_tc when the
// request is illegal and the turn expires on the same edge. Requests in
// CHECK or a terminal state get no answer. restart_tc beats everything.
module turn_sequencer
  import tictactoe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int CNT_W          = 30
) (
  input  logic              clk_tc,
  input  logic              rst_n_tc,
  input  logic              place_req_tc,
  input  logic [3:0]        cursor_tc,
  input  logic              restart_tc,
  output logic [GRID_W-1:0] p1Grid_tc,
  output logic [GRID_W-1:0] p2Grid_tc,
  output logic [2:0]        gameState_tc,
  output logic [3:0]        moveCount_tc,
  output logic              place_ack_tc,
  output logic              place_nack_tc,
  output logic              timeout_tc
);

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMER_EN = (TIMEOUT_CYCLES != 0);

  state_t            state_q, state_d;
  logic [GRID_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [3:0]        mc_q, mc_d;
  logic              ack_q, ack_d, nack_q, nack_d, to_q, to_d;
  logic              last_q, last_d;   // 0 = player 1 moved last, 1 = player 2
  logic [CNT_W-1:0]  timer_q, timer_d;

  logic [1:0]        row, col;
  logic [3:0]        cell_idx;
  logic [GRID_W-1:0] cell_mask;
  logic              illegal, expire, win;
  logic [GRID_W-1:0] mover_grid;

  // Cursor decode and move legality.
  always_comb begin
    row       = cursor_tc[3:2];
    col       = cursor_tc[1:0];
    cell_idx  = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
    cell_mask = GRID_W'(1) << cell_idx;
    illegal   = (row == 2'd3) || (col == 2'd3) || (|((p1_q | p2_q) & cell_mask));
    expire    = TIMER_EN && (timer_q == CNT_W'(1));
    mover_grid = last_q ? p2_q : p1_q;
  end

  line_checker u_line_checker (
    .grid (mover_grid),
    .win  (win)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    mc_d    = mc_q;
    last_d  = last_q;
    timer_d = timer_q;
    ack_d   = 1'b0;
    nack_d  = 1'b0;
    to_d    = 1'b0;
    if (restart_tc) begin
      state_d = ST_P1_TURN;
      p1_d    = '0;
      p2_d    = '0;
      mc_d    = 4'd0;
      timer_d = RELOAD;
    end else begin
      case (state_q)
        ST_P1_TURN, ST_P2_TURN: begin
          if (TIMER_EN) timer_d = timer_q - CNT_W'(1);
          if (place_req_tc && !illegal) begin
            if (state_q == ST_P1_TURN) p1_d = p1_q | cell_mask;
            else                       p2_d = p2_q | cell_mask;
            mc_d    = mc_q + 4'd1;
            ack_d   = 1'b1;
            last_d  = (state_q == ST_P2_TURN);
            state_d = ST_CHECK;
          end else if (expire) begin
            state_d = (state_q == ST_P1_TURN) ? ST_P2_TURN : ST_P1_TURN;
            to_d    = 1'b1;
            timer_d = RELOAD;
          end else if (place_req_tc) begin
            nack_d = 1'b1;
          end
        end
        ST_CHECK: begin
          if (win) begin
            state_d = last_q ? ST_P2_WIN : ST_P1_WIN;
          end else if (mc_q == 4'd9) begin
            state_d = ST_DRAW;
          end else begin
            state_d = last_q ? ST_P1_TURN : ST_P2_TURN;
            timer_d = RELOAD;
          end
        end
        default: ; // terminal states hold until restart
      endcase
    end
  end

  // State and registered-output flops.
  always_ff @(posedge clk_tc or negedge rst_n_tc) begin
    if (!rst_n_tc) begin
      state_q <= ST_P1_TURN;
      p1_q    <= '0;
      p2_q    <= '0;
      mc_q    <= 4'd0;
      last_q  <= 1'b0;
      timer_q <= RELOAD;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      mc_q    <= mc_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      to_q    <= to_d;
    end
  end

  assign p1Grid_tc     = p1_q;
  assign p2Grid_tc     = p2_q;
  assign gameState_tc  = state_q;
  assign moveCount_tc  = mc_q;
  assign place_ack_tc  = ack_q;
  assign place_nack_tc = nack_q;
  assign timeout_tc    = to_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: instance "a" has the timeout disabled,
// instance "b" uses an 8-cycle timeout.
module tb_turn_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: TIMEOUT_CYCLES = 0
  logic       rst_n_a, req_a, restart_a;
  logic [3:0] cursor_a;
  logic [8:0] p1_a, p2_a;
  logic [2:0] st_a;
  logic [3:0] mc_a;
  logic       ack_a, nack_a, to_a;

  // Instance b: TIMEOUT_CYCLES = 8
  logic       rst_n_b, req_b, restart_b;
  logic [3:0] cursor_b;
  logic [8:0] p1_b, p2_b;
  logic [2:0] st_b;
  logic [3:0] mc_b;
  logic       ack_b, nack_b, to_b;

  int checks = 0;
  int errors = 0;
  int cells [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  turn_sequencer #(.TIMEOUT_CYCLES(0), .CNT_W(30)) dut_a (
    .clk_tc(clk), .rst_n_tc(rst_n_a), .place_req_tc(req_a), .cursor_tc(cursor_a),
    .restart_tc(restart_a), .p1Grid_tc(p1_a), .p2Grid_tc(p2_a), .gameState_tc(st_a),
    .moveCount_tc(mc_a), .place_ack_tc(ack_a), .place_nack_tc(nack_a), .timeout_tc(to_a)
  );

  turn_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(30)) dut_b (
    .clk_tc(clk), .rst_n_tc(rst_n_b), .place_req_tc(req_b), .cursor_tc(cursor_b),
    .restart_tc(restart_b), .p1Grid_tc(p1_b), .p2Grid_tc(p2_b), .gameState_tc(st_b),
    .moveCount_tc(mc_b), .place_ack_tc(ack_b), .place_nack_tc(nack_b), .timeout_tc(to_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur(input int c);
    logic [1:0] r, k;
    r = 2'(c / 3);
    k = 2'(c % 3);
    return {r, k};
  endfunction

  task automatic place_a(input logic [3:0] c);
    cursor_a = c;
    req_a    = 1'b1;
    step();
    req_a    = 1'b0;
  endtask

  task automatic place_b(input logic [3:0] c);
    cursor_b = c;
    req_b    = 1'b1;
    step();
    req_b    = 1'b0;
  endtask

  task automatic restart_pulse_a();
    restart_a = 1'b1;
    step();
    restart_a = 1'b0;
  endtask

  initial begin
    rst_n_a = 1'b0; req_a = 1'b0; restart_a = 1'b0; cursor_a = 4'd0;
    rst_n_b = 1'b0; req_b = 1'b0; restart_b = 1'b0; cursor_b = 4'd0;
    step();
    step();

    // ---------------- instance a: reset and idle ----------------
    rst_n_a = 1'b1;
    repeat (5) step();
    chk("idle_p1", 32'(p1_a), 32'h000);
    chk("idle_p2", 32'(p2_a), 32'h000);
    chk("idle_state", 32'(st_a), 32'd0);
    chk("idle_mc", 32'(mc_a), 32'd0);
    chk("idle_pulses", 32'({ack_a, nack_a, to_a}), 32'd0);

    // P1 at (0,0)
    place_a(4'b0000);
    chk("m1_ack", 32'(ack_a), 32'd1);
    chk("m1_p1", 32'(p1_a), 32'h001);
    chk("m1_state_check", 32'(st_a), 32'd5);
    chk("m1_mc", 32'(mc_a), 32'd1);
    step();
    chk("m1_state_p2", 32'(st_a), 32'd1);
    chk("m1_ack_clear", 32'(ack_a), 32'd0);

    // P2 illegal: occupied cell, then column 3
    place_a(4'b0000);
    chk("nack_occ", 32'({ack_a, nack_a}), 32'b01);
    chk("nack_occ_state", 32'(st_a), 32'd1);
    place_a(4'b0011);
    chk("nack_col3", 32'({ack_a, nack_a}), 32'b01);
    chk("nack_col3_p2", 32'(p2_a), 32'h000);
    chk("nack_col3_state", 32'(st_a), 32'd1);
    step();
    chk("nack_clear", 32'(nack_a), 32'd0);

    // P2(1,0), P1(0,1), P2(1,1), P1(0,2): P1 completes the top row
    place_a(4'b0100); step();
    place_a(4'b0001); step();
    place_a(4'b0101); step();
    place_a(4'b0010);
    chk("win_ack", 32'(ack_a), 32'd1);
    step();
    chk("win_p1", 32'(p1_a), 32'h007);
    chk("win_p2", 32'(p2_a), 32'h018);
    chk("win_state", 32'(st_a), 32'd2);
    chk("win_mc", 32'(mc_a), 32'd5);
    place_a(4'b1010);
    chk("term_no_resp", 32'({ack_a, nack_a}), 32'b00);
    chk("term_hold", 32'(st_a), 32'd2);

    restart_pulse_a();
    chk("rst1_state", 32'(st_a), 32'd0);
    chk("rst1_grids", 32'({p1_a, p2_a}), 32'd0);
    chk("rst1_mc", 32'(mc_a), 32'd0);

    // Nine-move draw
    for (int i = 0; i < 9; i++) begin
      place_a(cur(cells[i]));
      chk($sformatf("draw_ack%0d", i), 32'(ack_a), 32'd1);
      step();
      if (i < 8) chk($sformatf("draw_turn%0d", i), 32'(st_a), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk("draw_state", 32'(st_a), 32'd4);
    chk("draw_mc", 32'(mc_a), 32'd9);
    chk("draw_p1", 32'(p1_a), 32'h18D);
    chk("draw_p2", 32'(p2_a), 32'h072);
    restart_pulse_a();
    chk("rst2_state", 32'(st_a), 32'd0);
    chk("rst2_grids", 32'({p1_a, p2_a}), 32'd0);
    chk("rst2_mc", 32'(mc_a), 32'd0);

    // ---------------- instance b: 8-cycle timeout ----------------
    rst_n_b = 1'b1;
    repeat (7) step();
    chk("to_early", 32'(to_b), 32'd0);
    chk("to_early_state", 32'(st_b), 32'd0);
    step();
    chk("to_fire", 32'(to_b), 32'd1);
    chk("to_fire_state", 32'(st_b), 32'd1);

    // P2 places on the very cycle its turn expires
    repeat (7) step();
    chk("to2_early", 32'(to_b), 32'd0);
    place_b(4'b0000);
    chk("expire_pulses", 32'({ack_b, nack_b, to_b}), 32'b100);
    chk("expire_state", 32'(st_b), 32'd5);
    chk("expire_p2", 32'(p2_b), 32'h001);

    // Restart while in CHECK
    restart_b = 1'b1;
    step();
    restart_b = 1'b0;
    chk("rstc_state", 32'(st_b), 32'd0);
    chk("rstc_grids", 32'({p1_b, p2_b}), 32'd0);
    chk("rstc_mc", 32'(mc_b), 32'd0);
    chk("rstc_pulses", 32'({ack_b, nack_b, to_b}), 32'd0);
    repeat (7) step();
    chk("rstc_to_early", 32'(to_b), 32'd0);
    step();
    chk("rstc_to_fire", 32'(to_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
